mithril_add_secure: RTL and testbench

MITHRIL_ADD_SECURE -- requirements
Module: mithril_add_secure

---
 rtl/mithril_pkg.sv | 14 +
 rtl/mithril_limb_adder.sv | 17 +
 rtl/mithril_add_secure.sv | 127 ++++++++++++
 tb/tb_mithril_add_secure.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mithril_pkg.sv
// Shared state encoding and default geometry
// for the multi-cycle limb adder.
package mithril_pkg;

  localparam int unsigned WIDTH_DEF  = 256;
  localparam int unsigned LIMB_W_DEF = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/mithril_limb_adder.sv
// Combinational LIMB_W-bit adder with carry
// in and carry out.
module mithril_limb_adder #(
  parameter int unsigned LIMB_W = 64
) (
  input  logic [LIMB_W-1:0] a_i,
  input  logic [LIMB_W-1:0] b_i,
  input  logic              c_i,
  output logic [LIMB_W-1:0] s_o,
  output logic              c_o
);

  assign {c_o, s_o} = {1'b0, a_i}
                    + {1'b0, b_i}
                    + {{LIMB_W{1'b0}}, c_i};

endmodule

// File: rtl/mithril_add_secure.sv
// Constant-time limb-serial adder, one limb per cycle.
// Redundant full-width check: MITHRIL_ADD_FAULT_CHECK_EN.
module mithril_add_secure
  import mithril_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned LIMB_W = LIMB_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             done,
  output logic             error
);

  localparam int unsigned NL = WIDTH / LIMB_W;
  localparam int unsigned IW =
    (NL > 1) ? $clog2(NL) : 1;
  localparam logic [IW-1:0] LAST = IW'(NL - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [IW-1:0]    idx_q;
  logic             cy_q;
  logic [WIDTH-1:0] res_q;
  logic             co_q;
  logic             done_q;
  logic             err_q;

  logic [LIMB_W-1:0] la;
  logic [LIMB_W-1:0] lb;
  logic [LIMB_W-1:0] ls;
  logic              lc;
  logic              fault;

  always_comb begin
    la = a_q[idx_q*LIMB_W +: LIMB_W];
    lb = b_q[idx_q*LIMB_W +: LIMB_W];
  end

  mithril_limb_adder #(
    .LIMB_W (LIMB_W)
  ) u_limb (
    .a_i (la),
    .b_i (lb),
    .c_i (cy_q),
    .s_o (ls),
    .c_o (lc)
  );

  always_comb begin
    acc_d = acc_q;
    acc_d[idx_q*LIMB_W +: LIMB_W] = ls;
  end

`ifdef MITHRIL_ADD_FAULT_CHECK_EN
  // Independent adder over the latched operands;
  // compared against the limb path on the last limb.
  logic [WIDTH:0] ref_sum;
  assign ref_sum = {1'b0, a_q} + {1'b0, b_q};
  assign fault   = (ref_sum != {lc, acc_d});
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      res_q   <= '0;
      co_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= start && (state_q != S_IDLE);
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= operand_a;
            b_q     <= operand_b;
            acc_q   <= '0;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cy_q  <= lc;
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            if (fault) begin
              res_q <= '0;
              co_q  <= 1'b0;
              err_q <= 1'b1;
            end else begin
              res_q <= acc_d;
              co_q  <= lc;
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result    = res_q;
  assign carry_out = co_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule

// File: tb/tb_mithril_add_secure.sv
// Scoreboard bench for mithril_add_secure.
// Expected sums come from a full-width model.
module tb_mithril_add_secure;

  localparam int W  = 256;
  localparam int LW = 64;
  localparam int NL = W / LW;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [W-1:0] result;
  logic         carry_out;
  logic         done;
  logic         error;

  int errs;
  int checks;

  logic [W:0] exp_q[$];

  mithril_add_secure #(
    .WIDTH  (W),
    .LIMB_W (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .result    (result),
    .carry_out (carry_out),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++)
      v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    operand_a = '0;
    operand_b = '0;
    #12;
    checks++;
    if (result !== '0) begin
      errs++;
      $display("FAIL reset_result got=%h exp=0",
               result);
    end
    checks++;
    if ({carry_out, done, error} !== 3'b000) begin
      errs++;
      $display("FAIL reset_flags got=%b exp=000",
               {carry_out, done, error});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({done, error} !== 2'b00) begin
      errs++;
      $display("FAIL idle_flags got=%b exp=00",
               {done, error});
    end
  endtask

  task automatic run_add(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input string        nm
  );
    logic [W:0] exp;
    int lat;
    lat = 0;
    exp_q.push_back({1'b0, a} + {1'b0, b});
    @(posedge clk);
    #1;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    operand_a = rnd();
    operand_b = rnd();
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    exp = exp_q.pop_front();
    checks++;
    if (lat != NL) begin
      errs++;
      $display("FAIL %s_latency got=%0d exp=%0d",
               nm, lat, NL);
    end
    if (lat != 0) begin
      checks++;
      if (result !== exp[W-1:0]) begin
        errs++;
        $display("FAIL %s_result got=%h exp=%h",
                 nm, result, exp[W-1:0]);
      end
      checks++;
      if (carry_out !== exp[W]) begin
        errs++;
        $display("FAIL %s_carry got=%b exp=%b",
                 nm, carry_out, exp[W]);
      end
      checks++;
      if (error !== 1'b0) begin
        errs++;
        $display("FAIL %s_error got=%b exp=0",
                 nm, error);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || result !== exp[W-1:0]) begin
        errs++;
        $display("FAIL %s_hold done=%b res=%h exp=%h",
                 nm, done, result, exp[W-1:0]);
      end
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] ones;
    logic [W-1:0] one;
    ones = '1;
    one  = '0;
    one[0] = 1'b1;
    run_add({4{64'h123456789ABCDEF0}},
            {4{64'h0FEDCBA987654321}}, "pattern");
    checks++;
    if (result !== {4{64'h2222222222222211}}) begin
      errs++;
      $display("FAIL pattern_const got=%h", result);
    end
    run_add(ones, one, "wrap");
    checks++;
    if (result !== '0 || carry_out !== 1'b1) begin
      errs++;
      $display("FAIL wrap_const got=%h/%b exp=0/1",
               result, carry_out);
    end
    run_add('0, '0, "zero");
    run_add({32{8'h11}}, {32{8'h22}}, "b2b_33");
    run_add({32{8'hAA}}, {32{8'h55}}, "b2b_ff");
    checks++;
    if (result !== ones || carry_out !== 1'b0) begin
      errs++;
      $display("FAIL ff_const got=%h/%b",
               result, carry_out);
    end
    run_add({4{64'hFFFFFFFFFFFFFFFF}},
            {{3{64'h0}}, 64'h1}, "ripple");
    for (int i = 0; i < 6; i++)
      run_add(rnd(), rnd(), "random");
  endtask

  task automatic test_start_in_run();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   exp;
    a = rnd();
    b = rnd();
    exp_q.push_back({1'b0, a} + {1'b0, b});
    @(posedge clk);
    #1;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    operand_a = rnd();
    operand_b = rnd();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (error !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL run_reject err=%b done=%b exp=1/0",
               error, done);
    end
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errs++;
      $display("FAIL run_done done=%b err=%b exp=1/0",
               done, error);
    end
    checks++;
    if ({carry_out, result} !== exp) begin
      errs++;
      $display("FAIL run_result got=%h exp=%h",
               {carry_out, result}, exp);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || error !== 1'b0) begin
        errs++;
        $display("FAIL run_extra done=%b err=%b",
                 done, error);
      end
    end
  endtask

  task automatic test_start_in_done();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   exp;
    a = rnd();
    b = rnd();
    run_add(a, b, "pre_done");
    exp = {1'b0, a} + {1'b0, b};
    a = rnd();
    b = rnd();
    @(posedge clk);
    #1;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    start = 1'b1;
    operand_a = rnd();
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (error !== 1'b1) begin
      errs++;
      $display("FAIL done_reject err=%b exp=1", error);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
        errs++;
        $display("FAIL done_extra done=%b exp=0", done);
      end
    end
    exp = {1'b0, a} + {1'b0, b};
    checks++;
    if ({carry_out, result} !== exp) begin
      errs++;
      $display("FAIL done_hold got=%h exp=%h",
               {carry_out, result}, exp);
    end
  endtask

  task automatic test_reset_mid_run();
    int dn;
    dn = 0;
    @(posedge clk);
    #1;
    operand_a = rnd();
    operand_b = rnd();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (result !== '0 || carry_out !== 1'b0) begin
      errs++;
      $display("FAIL rst_run_data got=%h/%b exp=0/0",
               result, carry_out);
    end
    checks++;
    if ({done, error} !== 2'b00) begin
      errs++;
      $display("FAIL rst_run_flags got=%b exp=00",
               {done, error});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    checks++;
    if (dn != 0) begin
      errs++;
      $display("FAIL rst_run_done got=%0d exp=0", dn);
    end
    run_add(rnd(), rnd(), "after_rst");
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    test_reset();
    test_vectors();
    test_start_in_run();
    test_start_in_done();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
